ring_stop: RTL and testbench

RING_STOP -- requirements
Module: ring_stop

---
 rtl/ring_stop.sv | 151 +++++++++++++++
 tb/tb_ring_stop.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ring_stop.sv
// Ring stop: forwards ring slots, strips messages addressed to this core, and
// lends the token to the local messenger. Optional error flag via RING_ERR_EN.
module ring_stop (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  whichCore,
    input  logic [31:0] RingIn,
    input  logic [3:0]  SlotTypeIn,
    input  logic [3:0]  SourceIn,
    output logic [31:0] RingOut,
    output logic [3:0]  SlotTypeOut,
    output logic [3:0]  SourceOut,
    input  logic [31:0] msgrRingOut,
    input  logic [3:0]  msgrSlotTypeOut,
    input  logic [3:0]  msgrSourceOut,
    input  logic        msgrDriveRing,
    input  logic        msgrWantsToken,
    output logic        msgrAcquireToken,
    output logic        ringErr
);

    localparam logic [3:0] SLOT_TOKEN = 4'd1;
    localparam logic [3:0] SLOT_NULL  = 4'd7;
    localparam logic [3:0] SLOT_MSG   = 4'd8;

    typedef enum logic [1:0] {PASS, HOLD, RELEASE} state_e;

    state_e      state_q, state_d;
    logic [31:0] ring_q, ring_d;
    logic [3:0]  slot_type_q, slot_type_d;
    logic [3:0]  source_q, source_d;
    logic [5:0]  in_len_q, in_len_d;
    logic        strip_q, strip_d;
    logic        first_q;
    logic        is_header;
    logic        acquire;

    always_comb begin
        is_header = (SlotTypeIn == SLOT_MSG) && (in_len_q == '0);

        in_len_d = in_len_q;
        if (in_len_q != '0)
            in_len_d = in_len_q - 6'd1;
        else if (SlotTypeIn == SLOT_MSG)
            in_len_d = RingIn[5:0];

        strip_d = strip_q;
        if (in_len_q == '0)
            strip_d = is_header && (RingIn[17:14] == whichCore);

        acquire = (state_q == PASS) && !reset && !first_q &&
                  (SlotTypeIn == SLOT_TOKEN) && msgrWantsToken;

        state_d     = state_q;
        ring_d      = RingIn;
        slot_type_d = SlotTypeIn;
        source_d    = SourceIn;

        case (state_q)
            PASS: begin
                if (acquire) begin
                    state_d     = HOLD;
                    ring_d      = msgrRingOut;
                    slot_type_d = msgrSlotTypeOut;
                    source_d    = msgrSourceOut;
                end else if ((is_header && (RingIn[17:14] == whichCore)) ||
                             ((in_len_q != '0) && strip_q)) begin
                    ring_d      = '0;
                    slot_type_d = SLOT_NULL;
                    source_d    = '0;
                end
            end
            HOLD: begin
                if (msgrDriveRing) begin
                    ring_d      = msgrRingOut;
                    slot_type_d = msgrSlotTypeOut;
                    source_d    = msgrSourceOut;
                end else begin
                    // Token is loaded into the output register here so it is
                    // on the ring for exactly the cycle spent in RELEASE.
                    state_d     = RELEASE;
                    ring_d      = '0;
                    slot_type_d = SLOT_TOKEN;
                    source_d    = whichCore;
                end
            end
            default: begin
                state_d     = PASS;
                ring_d      = '0;
                slot_type_d = SLOT_NULL;
                source_d    = '0;
            end
        endcase

        // First slot after reset: core 1 injects the only ring token.
        if (first_q) begin
            ring_d      = '0;
            slot_type_d = (whichCore == 4'd1) ? SLOT_TOKEN : SLOT_NULL;
            source_d    = (whichCore == 4'd1) ? whichCore : 4'd0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= PASS;
            ring_q      <= '0;
            slot_type_q <= SLOT_NULL;
            source_q    <= '0;
            in_len_q    <= '0;
            strip_q     <= 1'b0;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            ring_q      <= ring_d;
            slot_type_q <= slot_type_d;
            source_q    <= source_d;
            in_len_q    <= in_len_d;
            strip_q     <= strip_d;
            first_q     <= 1'b0;
        end
    end

`ifdef RING_ERR_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q;
        if ((state_q != PASS) && (SlotTypeIn != SLOT_NULL))
            err_d = 1'b1;
        if ((SlotTypeIn == SLOT_MSG) && (in_len_q != '0) && (RingIn[5:0] != '0))
            err_d = 1'b1;
    end

    always_ff @(posedge clock) begin
        if (reset)
            err_q <= 1'b0;
        else
            err_q <= err_d;
    end

    assign ringErr = err_q;
`else
    assign ringErr = 1'b0;
`endif

    assign RingOut          = ring_q;
    assign SlotTypeOut      = slot_type_q;
    assign SourceOut        = source_q;
    assign msgrAcquireToken = acquire;

endmodule

// File: tb/tb_ring_stop.sv
// Self-checking bench for ring_stop: vector table plus scoreboarded sequences
// for reset injection, broadcast stripping, reset mid-hold and error flag.
module tb_ring_stop;

    localparam logic [3:0] TOK = 4'd1;
    localparam logic [3:0] NUL = 4'd7;
    localparam logic [3:0] MSG = 4'd8;

    typedef struct packed {
        logic [3:0]  st;
        logic [31:0] ring;
        logic [3:0]  src;
    } slot_t;

    typedef struct {
        slot_t in;
        logic  want;
        logic  drv;
        slot_t m;
        logic  acq;
        slot_t exp;
    } vec_t;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  whichCore;
    logic [31:0] RingIn;
    logic [3:0]  SlotTypeIn;
    logic [3:0]  SourceIn;
    logic [31:0] RingOut;
    logic [3:0]  SlotTypeOut;
    logic [3:0]  SourceOut;
    logic [31:0] msgrRingOut;
    logic [3:0]  msgrSlotTypeOut;
    logic [3:0]  msgrSourceOut;
    logic        msgrDriveRing;
    logic        msgrWantsToken;
    logic        msgrAcquireToken;
    logic        ringErr;

    int    total = 0;
    int    bad   = 0;
    slot_t sb_q[$];
    vec_t  vecs[15];
    logic  exp_err;

    always #5 clock = ~clock;

    ring_stop dut (
        .clock(clock), .reset(reset), .whichCore(whichCore),
        .RingIn(RingIn), .SlotTypeIn(SlotTypeIn), .SourceIn(SourceIn),
        .RingOut(RingOut), .SlotTypeOut(SlotTypeOut), .SourceOut(SourceOut),
        .msgrRingOut(msgrRingOut), .msgrSlotTypeOut(msgrSlotTypeOut),
        .msgrSourceOut(msgrSourceOut), .msgrDriveRing(msgrDriveRing),
        .msgrWantsToken(msgrWantsToken), .msgrAcquireToken(msgrAcquireToken),
        .ringErr(ringErr)
    );

    function automatic slot_t mk(logic [3:0] st, logic [31:0] ring, logic [3:0] src);
        mk = '{st: st, ring: ring, src: src};
    endfunction

    function automatic logic [31:0] hdr(logic [3:0] dest, logic [3:0] src, logic [5:0] len);
        hdr = {14'd0, dest, src, 4'd0, len};
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // One ring cycle: drive inputs, check the combinational grant, push the
    // expected registered slot, then pop and compare after the edge.
    task automatic step(string name, slot_t in, logic want, logic drv, slot_t m,
                        logic exp_acq, slot_t exp);
        slot_t got;
        slot_t e;
        SlotTypeIn      = in.st;
        RingIn          = in.ring;
        SourceIn        = in.src;
        msgrWantsToken  = want;
        msgrDriveRing   = drv;
        msgrSlotTypeOut = m.st;
        msgrRingOut     = m.ring;
        msgrSourceOut   = m.src;
        #1;
        check({name, ".acq"}, {31'd0, msgrAcquireToken}, {31'd0, exp_acq});
        sb_q.push_back(exp);
        @(posedge clock);
        #1;
        e   = sb_q.pop_front();
        got = mk(SlotTypeOut, RingOut, SourceOut);
        check({name, ".type"}, {28'd0, got.st}, {28'd0, e.st});
        check({name, ".ring"}, got.ring, e.ring);
        check({name, ".src"},  {28'd0, got.src}, {28'd0, e.src});
    endtask

    task automatic do_reset(logic [3:0] core);
        whichCore       = core;
        reset           = 1'b1;
        SlotTypeIn      = NUL;
        RingIn          = '0;
        SourceIn        = '0;
        msgrWantsToken  = 1'b0;
        msgrDriveRing   = 1'b0;
        msgrSlotTypeOut = NUL;
        msgrRingOut     = '0;
        msgrSourceOut   = '0;
        repeat (2) @(posedge clock);
        #1;
        check("rst.type", {28'd0, SlotTypeOut}, {28'd0, NUL});
        check("rst.ring", RingOut, 32'd0);
        check("rst.src",  {28'd0, SourceOut}, 32'd0);
        check("rst.err",  {31'd0, ringErr}, 32'd0);
        reset = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time %0t exceeded limit", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        slot_t idle;
        idle = mk(NUL, 32'd0, 4'd0);

        // Stop 3: strip own message, forward foreign one, token use.
        vecs[0]  = '{idle, 0, 0, idle, 0, idle};
        vecs[1]  = '{mk(MSG, hdr(3, 5, 2), 5), 0, 0, idle, 0, idle};
        vecs[2]  = '{mk(MSG, 32'h1111_1111, 5), 0, 0, idle, 0, idle};
        vecs[3]  = '{mk(MSG, 32'h2222_2222, 5), 0, 0, idle, 0, idle};
        vecs[4]  = '{mk(MSG, hdr(6, 3, 1), 3), 0, 0, idle, 0, mk(MSG, hdr(6, 3, 1), 3)};
        vecs[5]  = '{mk(MSG, 32'hDEAD_BEEF, 3), 0, 0, idle, 0, mk(MSG, 32'hDEAD_BEEF, 3)};
        vecs[6]  = '{mk(TOK, 32'd0, 9), 0, 0, idle, 0, mk(TOK, 32'd0, 9)};
        vecs[7]  = '{idle, 0, 0, idle, 0, idle};
        vecs[8]  = '{mk(TOK, 32'd0, 9), 1, 1, mk(MSG, hdr(7, 3, 3), 3), 1, mk(MSG, hdr(7, 3, 3), 3)};
        vecs[9]  = '{idle, 0, 1, mk(MSG, 32'hAAAA_0001, 3), 0, mk(MSG, 32'hAAAA_0001, 3)};
        vecs[10] = '{idle, 0, 1, mk(MSG, 32'hAAAA_0002, 3), 0, mk(MSG, 32'hAAAA_0002, 3)};
        vecs[11] = '{idle, 0, 1, mk(MSG, 32'hAAAA_0003, 3), 0, mk(MSG, 32'hAAAA_0003, 3)};
        vecs[12] = '{idle, 0, 0, idle, 0, mk(TOK, 32'd0, 3)};
        vecs[13] = '{mk(TOK, 32'd0, 9), 1, 0, idle, 0, idle};
        vecs[14] = '{mk(TOK, 32'd0, 5), 0, 0, idle, 0, mk(TOK, 32'd0, 5)};

`ifdef RING_ERR_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif

        do_reset(4'd3);
        for (int i = 0; i < 15; i++)
            step($sformatf("vec%0d", i), vecs[i].in, vecs[i].want, vecs[i].drv,
                 vecs[i].m, vecs[i].acq, vecs[i].exp);

        // Token injection on the first slot after reset.
        do_reset(4'd1);
        step("inj1", idle, 0, 0, idle, 0, mk(TOK, 32'd0, 1));
        step("inj1.next", idle, 0, 0, idle, 0, idle);
        do_reset(4'd4);
        step("inj4", idle, 0, 0, idle, 0, idle);

        // Reset in the middle of a held message: no token afterwards.
        step("hold.acq", mk(TOK, 32'd0, 1), 1, 1, mk(MSG, hdr(1, 4, 2), 4), 1,
             mk(MSG, hdr(1, 4, 2), 4));
        step("hold.w1", idle, 0, 1, mk(MSG, 32'h5555_0001, 4), 0, mk(MSG, 32'h5555_0001, 4));
        do_reset(4'd4);
        step("hold.rst0", idle, 0, 0, idle, 0, idle);
        step("hold.rst1", idle, 0, 0, idle, 0, idle);

        // Broadcast from core 2: forwarded by stop 4, stripped by stop 2.
        step("bc4.hdr", mk(MSG, hdr(2, 2, 1), 2), 0, 0, idle, 0, mk(MSG, hdr(2, 2, 1), 2));
        step("bc4.pay", mk(MSG, 32'h0BAD_CAFE, 2), 0, 0, idle, 0, mk(MSG, 32'h0BAD_CAFE, 2));
        do_reset(4'd2);
        step("bc2.first", idle, 0, 0, idle, 0, idle);
        step("bc2.hdr", mk(MSG, hdr(2, 2, 1), 2), 0, 0, idle, 0, idle);
        step("bc2.pay", mk(MSG, 32'h0BAD_CAFE, 2), 0, 0, idle, 0, idle);
        step("bc2.after", mk(MSG, hdr(5, 2, 0), 2), 0, 0, idle, 0, mk(MSG, hdr(5, 2, 0), 2));

        // Slot arriving while holding the token is dropped; flag is sticky.
        do_reset(4'd3);
        step("err.first", idle, 0, 0, idle, 0, idle);
        step("err.acq", mk(TOK, 32'd0, 1), 1, 1, mk(MSG, hdr(6, 3, 1), 3), 1,
             mk(MSG, hdr(6, 3, 1), 3));
        step("err.drop", mk(MSG, hdr(4, 1, 0), 1), 0, 1, mk(MSG, 32'h7777_0001, 3), 0,
             mk(MSG, 32'h7777_0001, 3));
        check("err.set", {31'd0, ringErr}, {31'd0, exp_err});
        step("err.rel", idle, 0, 0, idle, 0, mk(TOK, 32'd0, 3));
        step("err.pass", idle, 0, 0, idle, 0, idle);
        step("err.idle", idle, 0, 0, idle, 0, idle);
        check("err.sticky", {31'd0, ringErr}, {31'd0, exp_err});
        do_reset(4'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
